// File: rtl/multicycle_controller.sv
// Multicycle sequencing FSM: fetch/decode/exec/mem/wb control
// and arbitration of the shared memory port.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       alu_src_b,
  output logic [1:0] alu_op,
  output logic [2:0] imm_type,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       trap,
  output logic [2:0] state
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd7;

  localparam logic [2:0] C_R     = 3'd0;
  localparam logic [2:0] C_IALU  = 3'd1;
  localparam logic [2:0] C_LOAD  = 3'd2;
  localparam logic [2:0] C_STORE = 3'd3;
  localparam logic [2:0] C_BR    = 3'd4;
  localparam logic [2:0] C_JAL   = 3'd5;
  localparam logic [2:0] C_JALR  = 3'd6;
  localparam logic [2:0] C_ILL   = 3'd7;

  logic [2:0] state_q, state_d;
  logic [2:0] cls_q, cls_d;
  logic [2:0] imm_q, imm_d;

  logic       mreq_c, mwe_c, iord_c;
  logic       irw_c, pcw_c, asb_c;
  logic       rw_c, trap_c;
  logic [1:0] pcsrc_c, aluop_c, wbsel_c;
  logic [2:0] imm_c;

  always_comb begin
    cls_d = C_ILL;
    imm_d = 3'b000;
    unique case (1'b1)
      opcode == 7'b0110011: cls_d = C_R;
      opcode == 7'b0010011: cls_d = C_IALU;
      opcode == 7'b0000011: cls_d = C_LOAD;
      opcode == 7'b0100011: begin
        cls_d = C_STORE;
        imm_d = 3'b001;
      end
      opcode == 7'b1100011: begin
        cls_d = C_BR;
        imm_d = 3'b101;
      end
      opcode == 7'b1101111: begin
        cls_d = C_JAL;
        imm_d = 3'b110;
      end
      opcode == 7'b1100111: cls_d = C_JALR;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:
        if (mem_ready) state_d = S_DECODE;
      S_DECODE:
        state_d = (cls_d == C_ILL) ? S_TRAP : S_EXEC;
      S_EXEC:
        unique case (cls_q)
          C_BR:    state_d = S_FETCH;
          C_LOAD,
          C_STORE: state_d = S_MEM;
          default: state_d = S_WB;
        endcase
      S_MEM:
        if (mem_ready)
          state_d = (cls_q == C_STORE) ? S_FETCH : S_WB;
      S_WB:    state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cls_q   <= C_R;
      imm_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        cls_q <= cls_d;
        imm_q <= imm_d;
      end
    end
  end

  // Immediate format is visible already in DECODE, then held.
  assign imm_c = (state_q == S_DECODE) ? imm_d : imm_q;

  always_comb begin
    mreq_c  = 1'b0;
    mwe_c   = 1'b0;
    iord_c  = 1'b0;
    irw_c   = 1'b0;
    pcw_c   = 1'b0;
    pcsrc_c = 2'b00;
    asb_c   = 1'b0;
    aluop_c = 2'b00;
    rw_c    = 1'b0;
    wbsel_c = 2'b00;
    trap_c  = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mreq_c = 1'b1;
        irw_c  = mem_ready;
        pcw_c  = mem_ready;
      end
      S_EXEC:
        unique case (cls_q)
          C_R:     aluop_c = 2'b10;
          C_IALU: begin
            aluop_c = 2'b10;
            asb_c   = 1'b1;
          end
          C_LOAD,
          C_STORE: asb_c = 1'b1;
          C_BR: begin
            aluop_c = 2'b01;
            pcsrc_c = 2'b01;
            pcw_c   = branch_taken;
          end
          C_JAL: begin
            pcw_c   = 1'b1;
            pcsrc_c = 2'b01;
          end
          C_JALR: begin
            asb_c   = 1'b1;
            pcw_c   = 1'b1;
            pcsrc_c = 2'b10;
          end
          default: ;
        endcase
      S_MEM: begin
        mreq_c = 1'b1;
        iord_c = 1'b1;
        mwe_c  = (cls_q == C_STORE);
      end
      S_WB: begin
        rw_c = 1'b1;
        unique case (cls_q)
          C_LOAD:  wbsel_c = 2'b01;
          C_JAL,
          C_JALR:  wbsel_c = 2'b10;
          default: wbsel_c = 2'b00;
        endcase
      end
      S_TRAP:  trap_c = 1'b1;
      default: ;
    endcase
  end

  // Reset kills every output at once, even mid-access.
  assign mem_req   = rst_n & mreq_c;
  assign mem_we    = rst_n & mwe_c;
  assign iord      = rst_n & iord_c;
  assign ir_write  = rst_n & irw_c;
  assign pc_write  = rst_n & pcw_c;
  assign pc_src    = {2{rst_n}} & pcsrc_c;
  assign alu_src_b = rst_n & asb_c;
  assign alu_op    = {2{rst_n}} & aluop_c;
  assign imm_type  = (trap_c || !rst_n) ? 3'b000 : imm_c;
  assign reg_write = rst_n & rw_c;
  assign wb_sel    = {2{rst_n}} & wbsel_c;
  assign trap      = rst_n & trap_c;
  assign state     = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed vector bench for multicycle_controller.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       branch_taken;
  logic       mem_ready;
  logic       mem_req, mem_we, iord;
  logic       ir_write, pc_write;
  logic [1:0] pc_src;
  logic       alu_src_b;
  logic [1:0] alu_op;
  logic [2:0] imm_type;
  logic       reg_write;
  logic [1:0] wb_sel;
  logic       trap;
  logic [2:0] state;

  int checks = 0;
  int failures = 0;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [6:0] OP_JL = 7'b1101111;
  localparam logic [6:0] OP_JR = 7'b1100111;
  localparam logic [6:0] OP_XX = 7'b0000000;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .imm_type(imm_type),
    .reg_write(reg_write), .wb_sel(wb_sel),
    .trap(trap), .state(state)
  );

  always #5 clk = ~clk;

  // {mreq,mwe,iord,irw,pcw}_{pcsrc}_{asb}_{aluop}_{imm}_{rw}_{wbsel}_{trap}
  logic [16:0] act;
  assign act = {mem_req, mem_we, iord, ir_write, pc_write,
                pc_src, alu_src_b, alu_op, imm_type,
                reg_write, wb_sel, trap};

  typedef struct {
    logic [6:0]  op;
    logic        bt;
    logic        mr;
    logic [2:0]  st;
    logic [16:0] ctl;
  } vec_t;

  localparam int NV = 39;
  vec_t tv [NV];

  task automatic chk(input string name, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, a, e);
    end
  endtask

  initial begin
    // R-type, zero wait: 4 cycles
    tv[0]  = '{OP_R,  1'b0, 1'b1, 3'd0, 17'b10011_00_0_00_000_0_00_0};
    tv[1]  = '{OP_R,  1'b0, 1'b1, 3'd1, 17'b00000_00_0_00_000_0_00_0};
    tv[2]  = '{OP_R,  1'b0, 1'b1, 3'd2, 17'b00000_00_0_10_000_0_00_0};
    tv[3]  = '{OP_R,  1'b0, 1'b1, 3'd4, 17'b00000_00_0_00_000_1_00_0};
    // LOAD, 2 fetch waits, 1 mem wait: 8 cycles
    tv[4]  = '{OP_LD, 1'b0, 1'b0, 3'd0, 17'b10000_00_0_00_000_0_00_0};
    tv[5]  = '{OP_LD, 1'b0, 1'b0, 3'd0, 17'b10000_00_0_00_000_0_00_0};
    tv[6]  = '{OP_LD, 1'b0, 1'b1, 3'd0, 17'b10011_00_0_00_000_0_00_0};
    tv[7]  = '{OP_LD, 1'b0, 1'b1, 3'd1, 17'b00000_00_0_00_000_0_00_0};
    tv[8]  = '{OP_LD, 1'b0, 1'b1, 3'd2, 17'b00000_00_1_00_000_0_00_0};
    tv[9]  = '{OP_LD, 1'b0, 1'b0, 3'd3, 17'b10100_00_0_00_000_0_00_0};
    tv[10] = '{OP_LD, 1'b0, 1'b1, 3'd3, 17'b10100_00_0_00_000_0_00_0};
    tv[11] = '{OP_LD, 1'b0, 1'b1, 3'd4, 17'b00000_00_0_00_000_1_01_0};
    // STORE: no WB
    tv[12] = '{OP_ST, 1'b0, 1'b1, 3'd0, 17'b10011_00_0_00_000_0_00_0};
    tv[13] = '{OP_ST, 1'b0, 1'b1, 3'd1, 17'b00000_00_0_00_001_0_00_0};
    tv[14] = '{OP_ST, 1'b0, 1'b1, 3'd2, 17'b00000_00_1_00_001_0_00_0};
    tv[15] = '{OP_ST, 1'b0, 1'b1, 3'd3, 17'b11100_00_0_00_001_0_00_0};
    // BRANCH taken, then not taken
    tv[16] = '{OP_BR, 1'b1, 1'b1, 3'd0, 17'b10011_00_0_00_001_0_00_0};
    tv[17] = '{OP_BR, 1'b1, 1'b1, 3'd1, 17'b00000_00_0_00_101_0_00_0};
    tv[18] = '{OP_BR, 1'b1, 1'b1, 3'd2, 17'b00001_01_0_01_101_0_00_0};
    tv[19] = '{OP_BR, 1'b0, 1'b1, 3'd0, 17'b10011_00_0_00_101_0_00_0};
    tv[20] = '{OP_BR, 1'b0, 1'b1, 3'd1, 17'b00000_00_0_00_101_0_00_0};
    tv[21] = '{OP_BR, 1'b0, 1'b1, 3'd2, 17'b00000_01_0_01_101_0_00_0};
    // JAL
    tv[22] = '{OP_JL, 1'b0, 1'b1, 3'd0, 17'b10011_00_0_00_101_0_00_0};
    tv[23] = '{OP_JL, 1'b0, 1'b1, 3'd1, 17'b00000_00_0_00_110_0_00_0};
    tv[24] = '{OP_JL, 1'b0, 1'b1, 3'd2, 17'b00001_01_0_00_110_0_00_0};
    tv[25] = '{OP_JL, 1'b0, 1'b1, 3'd4, 17'b00000_00_0_00_110_1_10_0};
    // JALR
    tv[26] = '{OP_JR, 1'b0, 1'b1, 3'd0, 17'b10011_00_0_00_110_0_00_0};
    tv[27] = '{OP_JR, 1'b0, 1'b1, 3'd1, 17'b00000_00_0_00_000_0_00_0};
    tv[28] = '{OP_JR, 1'b0, 1'b1, 3'd2, 17'b00001_10_1_00_000_0_00_0};
    tv[29] = '{OP_JR, 1'b0, 1'b1, 3'd4, 17'b00000_00_0_00_000_1_10_0};
    // IALU
    tv[30] = '{OP_I,  1'b0, 1'b1, 3'd0, 17'b10011_00_0_00_000_0_00_0};
    tv[31] = '{OP_I,  1'b0, 1'b1, 3'd1, 17'b00000_00_0_00_000_0_00_0};
    tv[32] = '{OP_I,  1'b0, 1'b1, 3'd2, 17'b00000_00_1_10_000_0_00_0};
    tv[33] = '{OP_I,  1'b0, 1'b1, 3'd4, 17'b00000_00_0_00_000_1_00_0};
    // illegal opcode: TRAP is sticky
    tv[34] = '{OP_XX, 1'b0, 1'b1, 3'd0, 17'b10011_00_0_00_000_0_00_0};
    tv[35] = '{OP_XX, 1'b0, 1'b1, 3'd1, 17'b00000_00_0_00_000_0_00_0};
    tv[36] = '{OP_XX, 1'b0, 1'b1, 3'd7, 17'b00000_00_0_00_000_0_00_1};
    tv[37] = '{OP_XX, 1'b0, 1'b1, 3'd7, 17'b00000_00_0_00_000_0_00_1};
    tv[38] = '{OP_R,  1'b1, 1'b0, 3'd7, 17'b00000_00_0_00_000_0_00_1};

    rst_n = 1'b0;
    opcode = OP_R;
    branch_taken = 1'b0;
    mem_ready = 1'b0;
    #12;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_ctl", 32'(act), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      if (i != 0) @(negedge clk);
      opcode = tv[i].op;
      branch_taken = tv[i].bt;
      mem_ready = tv[i].mr;
      #1;
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(tv[i].st));
      chk($sformatf("vec%0d_ctl", i), 32'(act), 32'(tv[i].ctl));
    end

    // leave TRAP only by reset
    @(negedge clk);
    chk("trap_hold", 32'(trap), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("trap_rst_state", 32'(state), 32'd0);
    chk("trap_rst_trap", 32'(trap), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // reset mid-MEM with a pending store
    opcode = OP_ST;
    mem_ready = 1'b1;
    #1;
    chk("st_fetch_state", 32'(state), 32'd0);
    @(negedge clk);
    #1;
    chk("st_decode_state", 32'(state), 32'd1);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("st_exec_state", 32'(state), 32'd2);
    @(negedge clk);
    #1;
    chk("st_mem_state", 32'(state), 32'd3);
    chk("st_mem_req", 32'({mem_req, mem_we, iord}), 32'b111);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_no_rw", 32'({reg_write, pc_write, ir_write}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_state", 32'(state), 32'd0);
    chk("rel_fetch", 32'({mem_req, iord, ir_write}), 32'b100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing FSM for the multicycle core. Steps each instruction through fetch, decode, execute, memory and writeback, and drives the datapath enables, muxes and ALU mode. Also supplies the `imm_type` code consumed by `immediate_generator`. Sits beside the datapath, reads the opcode from the instruction register, and arbitrates the single shared memory port between instruction fetch and data access.

## Interface
- No parameters.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  7  instruction register bits [6:0]; stable from DECODE onward.
- `branch_taken`  in  1  ALU compare result, valid in EXEC.
- `mem_ready`  in  1  memory completion strobe; sampled only in FETCH and MEM.
- `mem_req`  out  1  memory access request.
- `mem_we`  out  1  write enable; store accesses only.
- `iord`  out  1  address select: 0 = PC, 1 = ALU result.
- `ir_write`  out  1  instruction register load.
- `pc_write`  out  1  PC load.
- `pc_src`  out  2  PC source: 00 = PC+4, 01 = PC-relative target, 10 = ALU result (JALR).
- `alu_src_b`  out  1  ALU B operand: 0 = rs2, 1 = immediate.
- `alu_op`  out  2  ALU mode: 00 = add, 01 = branch compare, 10 = funct-decoded.
- `imm_type`  out  3  immediate format: I = 000, S = 001, B = 101, J = 110.
- `reg_write`  out  1  register file write.
- `wb_sel`  out  2  writeback source: 00 = ALU, 01 = memory data, 10 = PC+4.
- `trap`  out  1  illegal-opcode halt indicator.
- `state`  out  3  current state, for debug.

## Operation
- State encoding: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 7.
- Supported instruction classes and opcodes:
  - R = 0110011, IALU = 0010011, LOAD = 0000011, STORE = 0100011
  - BRANCH = 1100011, JAL = 1101111, JALR = 1100111
  - Any other opcode is illegal.
- FETCH:
  - Assert `mem_req`=1 with `iord`=0.
  - When `mem_ready`=1 in the same cycle: assert `ir_write`=1, `pc_write`=1, `pc_src`=00, then go to DECODE.
  - Otherwise hold in FETCH. Wait states are unbounded.
- DECODE:
  - Classify `opcode` and register the class and `imm_type`.
  - `imm_type` mapping: IALU/LOAD/JALR → 000, STORE → 001, BRANCH → 101, JAL → 110, R → 000.
  - Illegal opcode → TRAP; otherwise → EXEC.
- EXEC:
  - R: `alu_op`=10, `alu_src_b`=0 → WB.
  - IALU: `alu_op`=10, `alu_src_b`=1 → WB.
  - LOAD/STORE: `alu_op`=00, `alu_src_b`=1 → MEM.
  - BRANCH: `alu_op`=01, `alu_src_b`=0, `pc_src`=01, `pc_write`=`branch_taken` → FETCH.
  - JAL: `pc_write`=1, `pc_src`=01 → WB.
  - JALR: `alu_op`=00, `alu_src_b`=1, `pc_write`=1, `pc_src`=10 → WB.
- MEM:
  - Assert `mem_req`=1, `iord`=1, and `mem_we`=1 for STORE only.
  - On `mem_ready`: STORE → FETCH, LOAD → WB. Otherwise hold.
- WB:
  - Assert `reg_write`=1.
  - `wb_sel`: LOAD → 01, JAL/JALR → 10, otherwise 00.
  - Then → FETCH.
- TRAP:
  - `trap`=1; every other control output is 0.
  - Stays in TRAP until reset.
- Registered class and `imm_type` hold their value from DECODE until the next DECODE.

## Timing
- Reset (async assert, synchronous release):
  - `state` = FETCH.
  - All outputs 0: `imm_type`=000, `trap`=0, `pc_src`=00, `wb_sel`=00.
  - `mem_req` drops immediately, even mid-access. The interrupted instruction is abandoned and no write or enable pulse is emitted.
- Output decode:
  - `ir_write` and `pc_write` in FETCH, and the MEM exit, are Mealy: gated by the same-cycle `mem_ready`.
  - All other outputs are Moore, decoded from `state` and the registered class.
- Cycle counts at zero wait (`mem_ready` high on first request cycle):
  - BRANCH = 3
  - R, IALU, STORE, JAL, JALR = 4
  - LOAD = 5
  - Each extra wait cycle adds 1.
- Memory handshake:
  - `mem_req` stays high every cycle in FETCH/MEM until the `mem_ready` cycle.
  - `mem_ready` in any other state is ignored.
  - A `mem_ready` already high on FETCH entry completes the access in that same cycle.
- Branch not taken: no PC write in EXEC; PC already holds PC+4 from FETCH.
- Single-cycle pulses: `reg_write` and `pc_write` are never high for more than one consecutive cycle per instruction step.

## Test plan
- Reset while in MEM with a pending store → `mem_req`=0 and `mem_we`=0 asynchronously; `state`=0 after release; no `reg_write` pulse.
- R-type (0110011), `mem_ready` held high → states 0,1,2,4,0; `reg_write`=1 only in cycle 4 with `wb_sel`=00; 4 cycles total.
- LOAD with 2 wait cycles in FETCH and 1 in MEM → total 8 cycles; `iord`=1 in MEM; `wb_sel`=01; `imm_type`=000 held DECODE through WB.
- STORE → `imm_type`=001; `mem_we`=1 only in MEM; returns to FETCH without WB; `reg_write` never asserted.
- BRANCH twice, `branch_taken`=1 then 0 → `imm_type`=101; `pc_write`=1 with `pc_src`=01 in EXEC only on the taken case; 3 cycles each.
- JAL then illegal opcode 0000000 → JAL gives `imm_type`=110, EXEC `pc_src`=01, WB `wb_sel`=10; illegal reaches TRAP after DECODE with `trap`=1, `mem_req`=0 held, and stays until `rst_n` pulse.
